// File: rtl/mem_write_checker.sv
// Checks committed data-memory stores against a table of expected stores, in program order.
// Reports pass/fail with the failing entry, the captured data and a failure code.
module mem_write_checker #(
    parameter int NUM_CHECKS = 4,
    parameter bit STRICT     = 1'b0,
    parameter int TIMEOUT    = 1000,
    localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_addr,
    input  logic [31:0]      cfg_data,
    input  logic             start,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [IDX_W-1:0] fail_index,
    output logic [31:0]      fail_data,
    output logic [IDX_W:0]   match_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] CODE_DATA    = 2'd1;
    localparam logic [1:0] CODE_ADDR    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W:0]   match_count_q, match_count_d;
    logic [1:0]       fail_code_q, fail_code_d;
    logic [IDX_W-1:0] fail_index_q, fail_index_d;
    logic [31:0]      fail_data_q, fail_data_d;
    logic [31:0]      tbl_addr_q [NUM_CHECKS];
    logic [31:0]      tbl_addr_d [NUM_CHECKS];
    logic [31:0]      tbl_data_q [NUM_CHECKS];
    logic [31:0]      tbl_data_d [NUM_CHECKS];

    logic             cfg_idx_ok;
    logic             last_entry;
    logic [31:0]      exp_addr;
    logic [31:0]      exp_data;
    logic [TMR_W-1:0] timer_inc;

    assign cfg_idx_ok = (32'(cfg_idx) < 32'(NUM_CHECKS));
    assign last_entry = (ptr_q == IDX_W'(NUM_CHECKS - 1));
    assign exp_addr   = tbl_addr_q[ptr_q];
    assign exp_data   = tbl_data_q[ptr_q];
    assign timer_inc  = timer_q + TMR_W'(1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        match_count_d = match_count_q;
        fail_code_d   = fail_code_q;
        fail_index_d  = fail_index_q;
        fail_data_d   = fail_data_q;
        tbl_addr_d    = tbl_addr_q;
        tbl_data_d    = tbl_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we && cfg_idx_ok) begin
                    tbl_addr_d[cfg_idx] = cfg_addr;
                    tbl_data_d[cfg_idx] = cfg_data;
                end
                if (start) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                    timer_d = '0;
                end
            end
            ST_RUN: begin
                // A store failure outranks a timeout on the same edge; a match cancels the timeout.
                if (MemWrite && (DataAdr == exp_addr)) begin
                    if (WriteData == exp_data) begin
                        match_count_d = match_count_q + 1'b1;
                        timer_d       = '0;
                        if (last_entry) begin
                            state_d = ST_PASS;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else begin
                        state_d      = ST_FAIL;
                        fail_code_d  = CODE_DATA;
                        fail_index_d = ptr_q;
                        fail_data_d  = WriteData;
                    end
                end else if (MemWrite && STRICT) begin
                    state_d      = ST_FAIL;
                    fail_code_d  = CODE_ADDR;
                    fail_index_d = ptr_q;
                    fail_data_d  = WriteData;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMR_W'(TIMEOUT)) begin
                        state_d      = ST_FAIL;
                        fail_code_d  = CODE_TIMEOUT;
                        fail_index_d = ptr_q;
                        fail_data_d  = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            timer_q       <= '0;
            match_count_q <= '0;
            fail_code_q   <= '0;
            fail_index_q  <= '0;
            fail_data_q   <= '0;
            tbl_addr_q    <= '{default: '0};
            tbl_data_q    <= '{default: '0};
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            match_count_q <= match_count_d;
            fail_code_q   <= fail_code_d;
            fail_index_q  <= fail_index_d;
            fail_data_q   <= fail_data_d;
            tbl_addr_q    <= tbl_addr_d;
            tbl_data_q    <= tbl_data_d;
        end
    end

    assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass        = (state_q == ST_PASS);
    assign fail_code   = fail_code_q;
    assign fail_index  = fail_index_q;
    assign fail_data   = fail_data_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: a lax and a strict checker share one write bus; a store-list reference
// model predicts each outcome and the cycle it appears, and per-instance monitors compare.
module tb_mem_write_checker;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int TO = 20;

    typedef struct packed {
        logic          mw;
        logic [31:0]   a;
        logic [31:0]   d;
        logic          we;
        logic          st;
        logic [IW-1:0] ci;
        logic [31:0]   ca;
        logic [31:0]   cd;
    } bus_t;

    typedef struct {
        logic          pass;
        logic [1:0]    code;
        logic [IW-1:0] idx;
        logic [31:0]   data;
        logic [IW:0]   mc;
        int            at;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [31:0]   cfg_addr, cfg_data;
    logic          start, mem_write;
    logic [31:0]   data_adr, write_data;

    logic          l_done, l_pass, s_done, s_pass;
    logic [1:0]    l_code, s_code;
    logic [IW-1:0] l_idx, s_idx;
    logic [31:0]   l_data, s_data;
    logic [IW:0]   l_mc, s_mc;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q_l[$];
    exp_t q_s[$];
    bus_t stim[$];
    logic [31:0] t_addr [N];
    logic [31:0] t_data [N];

    mem_write_checker #(.NUM_CHECKS(N), .STRICT(1'b0), .TIMEOUT(TO)) u_lax (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .MemWrite(mem_write), .DataAdr(data_adr),
        .WriteData(write_data), .done(l_done), .pass(l_pass), .fail_code(l_code),
        .fail_index(l_idx), .fail_data(l_data), .match_count(l_mc));

    mem_write_checker #(.NUM_CHECKS(N), .STRICT(1'b1), .TIMEOUT(TO)) u_strict (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .MemWrite(mem_write), .DataAdr(data_adr),
        .WriteData(write_data), .done(s_done), .pass(s_pass), .fail_code(s_code),
        .fail_index(s_idx), .fail_data(s_data), .match_count(s_mc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic dn, input logic ps,
                           input logic [1:0] cd, input logic [IW-1:0] ix,
                           input logic [31:0] fd, input logic [IW:0] mc);
        check({tag, "_done"}, 64'(dn), 64'(1));
        check({tag, "_pass"}, 64'(ps), 64'(e.pass));
        check({tag, "_code"}, 64'(cd), 64'(e.code));
        check({tag, "_index"}, 64'(ix), 64'(e.idx));
        check({tag, "_data"}, 64'(fd), 64'(e.data));
        check({tag, "_count"}, 64'(mc), 64'(e.mc));
    endtask

    // Walks the store list cycle by cycle after the start edge; c0 is cyc when start is driven.
    function automatic exp_t model(input bit strict, input int c0);
        exp_t e;
        bus_t b;
        int   ptr = 0;
        int   timer = 0;
        int   mc = 0;
        e.pass = 1'b0; e.code = 2'd3; e.idx = '0; e.data = '0; e.mc = '0; e.at = 0;
        for (int i = 1; i <= stim.size() + TO + 1; i++) begin
            b    = (i <= stim.size()) ? stim[i-1] : '0;
            e.at = c0 + 1 + i;
            e.idx = ptr[IW-1:0];
            e.mc  = mc[IW:0];
            if (b.mw && b.a == t_addr[ptr]) begin
                if (b.d == t_data[ptr]) begin
                    mc++; ptr++; timer = 0;
                    if (ptr == N) begin
                        e.pass = 1'b1; e.code = 2'd0; e.idx = '0; e.mc = mc[IW:0];
                        return e;
                    end
                end else begin
                    e.code = 2'd1; e.data = b.d;
                    return e;
                end
            end else if (b.mw && strict) begin
                e.code = 2'd2; e.data = b.d;
                return e;
            end else begin
                timer++;
                if (timer == TO) begin
                    e.code = 2'd3; e.data = '0;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input bus_t b);
        mem_write = b.mw; data_adr = b.a; write_data = b.d;
        cfg_we = b.we; start = b.st; cfg_idx = b.ci; cfg_addr = b.ca; cfg_data = b.cd;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        bus_t b = '0;
        b.mw = 1'b1; b.a = a; b.d = d;
        stim.push_back(b);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) stim.push_back('0);
    endtask

    task automatic set_directed();
        t_addr[0] = 32'd100; t_data[0] = 32'h0689_0000;
        t_addr[1] = 32'd104; t_data[1] = 32'h01B0_2B93;
        t_addr[2] = 32'd108; t_data[2] = 32'h0000_00A5;
    endtask

    task automatic load_table(input int upto);
        bus_t b;
        for (int k = 0; k < upto; k++) begin
            b = '0; b.we = 1'b1; b.ci = k[IW-1:0]; b.ca = t_addr[k]; b.cd = t_data[k];
            drive(b);
            @(negedge clk);
        end
    endtask

    // load=0 leaves the table zeroed and instead issues an out-of-range cfg write with start.
    task automatic do_test(input bit load);
        bus_t b;
        exp_t el, es;
        int   c0;
        reset = 1'b0;
        drive('0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        if (load) load_table(N - 1);
        b = '0; b.st = 1'b1; b.we = 1'b1;
        if (load) begin
            b.ci = IW'(N - 1); b.ca = t_addr[N-1]; b.cd = t_data[N-1];
        end else begin
            b.ci = IW'(N); b.ca = 32'd0; b.cd = 32'd5;
        end
        drive(b);
        c0 = cyc;
        el = model(1'b0, c0);
        es = model(1'b1, c0);
        q_l.push_back(el);
        q_s.push_back(es);
        @(negedge clk);
        foreach (stim[i]) begin
            drive(stim[i]);
            @(negedge clk);
        end
        drive('0);
        for (int k = 0; k < 3 * TO && !(l_done && s_done); k++) @(negedge clk);
        check("both_done", 64'({l_done, s_done}), 64'(2'b11));
        for (int k = 0; k < 6; k++) begin
            int j = $urandom_range(0, N - 1);
            b = '0; b.mw = 1'b1; b.a = t_addr[j]; b.d = t_data[j];
            b.st = 1'b1; b.we = 1'b1; b.ci = '0; b.ca = $urandom; b.cd = $urandom;
            drive(b);
            @(negedge clk);
        end
        drive('0);
        cmp_out("lax_hold", el, l_done, l_pass, l_code, l_idx, l_data, l_mc);
        cmp_out("strict_hold", es, s_done, s_pass, s_code, s_idx, s_data, s_mc);
        stim.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_lax"}, 64'({l_done, l_pass, l_code, l_idx, l_data, l_mc}), 64'(0));
        check({tag, "_strict"}, 64'({s_done, s_pass, s_code, s_idx, s_data, s_mc}), 64'(0));
    endtask

    task automatic gen_random();
        int j = 0;
        int r;
        for (int k = 0; k < N; k++) begin
            t_addr[k] = 32'd256 + 4 * $urandom_range(0, 31);
            t_data[k] = $urandom;
        end
        while (j < N && stim.size() < 60) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin push_store(t_addr[j], t_data[j]); j++; end
            else if (r < 70) push_idle(1);
            else if (r < 80) push_store(32'h8000_0000 | ($urandom & 32'h0FFF_FFFC), $urandom);
            else if (r < 85) push_store(t_addr[j], t_data[j] ^ (32'd1 << $urandom_range(0, 31)));
            else if (r < 90) push_idle($urandom_range(TO - 1, TO + 1));
            else if (j < N - 1) push_store(t_addr[N-1], t_data[N-1]);
            else push_idle(1);
        end
        foreach (stim[i]) begin
            stim[i].we = ($urandom_range(0, 3) == 0);
            stim[i].st = ($urandom_range(0, 3) == 0);
            stim[i].ci = IW'($urandom_range(0, 3));
            stim[i].ca = $urandom;
            stim[i].cd = $urandom;
        end
    endtask

    initial begin : monitor
        logic lp, sp;
        exp_t e;
        lp = 1'b0;
        sp = 1'b0;
        forever begin
            @(negedge clk);
            if (l_done && !lp) begin
                check("lax_expected_pending", 64'(q_l.size() > 0), 64'(1));
                if (q_l.size() > 0) begin
                    e = q_l.pop_front();
                    cmp_out("lax", e, l_done, l_pass, l_code, l_idx, l_data, l_mc);
                    check("lax_cycle", 64'(cyc), 64'(e.at));
                end
            end
            if (s_done && !sp) begin
                check("strict_expected_pending", 64'(q_s.size() > 0), 64'(1));
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    cmp_out("strict", e, s_done, s_pass, s_code, s_idx, s_data, s_mc);
                    check("strict_cycle", 64'(cyc), 64'(e.at));
                end
            end
            lp = l_done;
            sp = s_done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus_t b;
        reset = 1'b1;
        drive('0);
        #2 reset = 1'b0;
        #1 check_zero("reset_state");

        set_directed();
        push_store(32'd100, 32'h0689_0000); push_store(32'd104, 32'h01B0_2B93);
        push_store(32'd108, 32'h0000_00A5);
        do_test(1'b1);

        set_directed();
        push_store(32'd100, 32'h0689_0001);
        do_test(1'b1);

        set_directed();
        push_store(32'd96, 32'hDEAD_0000); push_store(32'd100, 32'h0689_0000);
        push_store(32'd104, 32'h01B0_2B93); push_store(32'd108, 32'h0000_00A5);
        do_test(1'b1);

        set_directed();
        do_test(1'b1);

        set_directed();
        push_idle(TO - 1); push_store(32'd100, 32'h0689_0000);
        push_store(32'd104, 32'h01B0_2B93); push_store(32'd108, 32'h0000_00A5);
        do_test(1'b1);

        set_directed();
        push_store(32'd100, 32'h0689_0000); push_idle(TO);
        push_store(32'd104, 32'h01B0_2B93);
        do_test(1'b1);

        set_directed();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        load_table(N);
        b = '0; b.st = 1'b1;
        drive(b);
        @(negedge clk);
        b = '0; b.mw = 1'b1; b.a = 32'd100; b.d = 32'h0689_0000;
        drive(b);
        @(negedge clk);
        drive('0);
        check("count_before_reset", 64'({l_mc, s_mc}), 64'({3'd1, 3'd1}));
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);

        for (int k = 0; k < N; k++) begin t_addr[k] = '0; t_data[k] = '0; end
        push_store(32'd0, 32'd0); push_store(32'd0, 32'd0); push_store(32'd0, 32'd0);
        do_test(1'b0);

        for (int t = 0; t < 30; t++) begin
            gen_random();
            do_test(1'b1);
        end

        check("lax_queue_drained", 64'(q_l.size()), 64'(0));
        check("strict_queue_drained", 64'(q_s.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
